nonce_gen_mc: RTL and testbench
===============================

Name: nonce_gen_mc

Overview:
- Multi-lane successor of the single-lane nonce generator in the miner datapath.
- Loads one 80-byte block header from the block-header FIFO and computes this instance's nonce slice.
- Distributes nonces round-robin across NUM_LANES hash cores. Each lane has its own hash-input FIFO and nonce FIFO.
- Range arithmetic is overflow-safe, a stop can be applied at any time, and completion is reported.

Parameters:
- NUM_LANES, 4, number of hash-core lanes (1..8).
- SLICE_IDX, 0, index of this instance's nonce slice (0..255); slice start = header nonce + nonce_size*SLICE_IDX.
- PAD_WORD, 64'h8000000000000280, first beat of every hash-input packet.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  new header available; sampled in IDLE
- stop  in  1  abort request; level-sensitive
- hdr_valid  in  1  header word valid
- hdr_ready  out  1  header word accepted when hdr_valid&hdr_ready
- hdr_word  in  32  header word
- nonce_size  in  32  slice length; latched at start
- hashin_we  out  NUM_LANES  per-lane hash FIFO write
- hashin_din  out  64*NUM_LANES  lane i uses bits [64i+:64]
- hashin_full  in  NUM_LANES  per-lane full flags
- nonce_we  out  NUM_LANES  per-lane nonce FIFO write
- nonce_din  out  32*NUM_LANES  lane i uses bits [32i+:32]
- nonce_full  in  NUM_LANES  per-lane full flags
- stop_ack  out  1  high while in IDLE
- done  out  1  one-cycle pulse when a range finishes or a stop completes
- nonce_end  out  32  latched exclusive end of the slice, saturated
- issued_cnt  out  32  nonces issued since the last start

Behaviour:
- Reset values: all outputs 0 except stop_ack=1. FSM goes to IDLE; rr_ptr=0; counters and header register cleared.
- IDLE: stop_ack=1, hdr_ready=0. On start, latch nonce_size, clear issued_cnt and word count, go to LOAD.
- LOAD: hdr_ready=1.
  - Word k (k=0..19, arrival order) is stored at hdr[32k+:32].
  - After the 20th accepted word go to RANGE.
  - No timeout. stop in LOAD goes to IDLE and pulses done.
- RANGE (one cycle), using 41-bit math:
  - base = w0 + nonce_size*SLICE_IDX.
  - end = base + nonce_size.
  - If nonce_size==0 or base >= 2^32: empty range. Go to IDLE, pulse done, nonce_end = 32'hFFFFFFFF if base >= 2^32, else base.
  - Otherwise nonce_end = min(end, 2^32) truncated, with 2^32 reported as 32'hFFFFFFFF. The internal 33-bit end is kept so nonce 32'hFFFFFFFF is issuable. Set cur = base and go to ISSUE.
- ISSUE:
  - If stop: go to IDLE and pulse done.
  - Else if cur >= end33: go to IDLE and pulse done.
  - Else pick the first lane L, searching from rr_ptr upward with wrap, with !hashin_full[L] && !nonce_full[L]. No eligible lane: wait.
  - On grant, in the same cycle:
    - hashin_we[L]=1 with din=PAD_WORD.
    - nonce_we[L]=1 with din=cur[31:0].
    - Snapshot pkt = {hdr[639:32], bswap32(cur)}.
    - cur++, issued_cnt++, rr_ptr = (L+1) mod NUM_LANES, beat=0. Go to BURST.
- BURST:
  - Emit pkt[639:576] then shift left 64, 10 beats total, on lane L only.
  - A beat is written only in cycles where !hashin_full[L]; otherwise we=0 and no advance.
  - After beat 10 return to ISSUE.
  - stop is ignored until the packet completes. Packets are never truncated.
- Minimum throughput: 11 cycles per nonce (1 ISSUE + 10 BURST).
- Only one lane has any write enable asserted per cycle. Idle lanes' din = 0.
- A stop and a grant in the same ISSUE cycle: stop wins and no write occurs.
- rst mid-packet: immediate return to reset values. A partial packet in a FIFO is the system's responsibility.
- issued_cnt wraps at 2^32.

Test Plan:
- NUM_LANES=4, SLICE_IDX=0, w0=0x00000010, nonce_size=8, no full flags -> nonces 0x10..0x17 go to lanes 0,1,2,3,0,1,2,3. Each packet is PAD_WORD then 10 beats whose last beat low word = 0x10000000 for nonce 0x10. Then done pulse, issued_cnt=8, nonce_end=0x18.
- SLICE_IDX=2, w0=0xFFFFFF00, nonce_size=0x100 -> base >= 2^32 gives an empty range: done with no writes, nonce_end=0xFFFFFFFF.
- SLICE_IDX=0, w0=0xFFFFFFFE, nonce_size=4 -> exactly nonces 0xFFFFFFFE and 0xFFFFFFFF are issued, nonce_end=0xFFFFFFFF, no wrap to 0.
- hashin_full[1]=1 throughout, 6 nonces -> lane 1 is skipped and order is 0,2,3,0,2,3. Holding hashin_full[2] for 5 cycles mid-burst stalls that packet with no lost or duplicate beats.
- stop asserted during beat 4 of a packet -> all 10 beats complete, then IDLE, done pulse, stop_ack=1. No further nonce writes.
- rst pulsed during LOAD after 7 words, then a fresh start plus 20 words -> a clean first packet with nonce = new w0.

Source files
------------

// File: rtl/nonce_gen_mc.sv
// Multi-lane nonce generator: loads an 80-byte header, computes this instance's
// nonce slice and deals nonces round-robin to NUM_LANES hash-core FIFOs.
module nonce_gen_mc #(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned SLICE_IDX = 0,
    parameter logic [63:0] PAD_WORD  = 64'h8000000000000280
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      hdr_valid,
    output logic                      hdr_ready,
    input  logic [31:0]               hdr_word,
    input  logic [31:0]               nonce_size,
    output logic [NUM_LANES-1:0]      hashin_we,
    output logic [64*NUM_LANES-1:0]   hashin_din,
    input  logic [NUM_LANES-1:0]      hashin_full,
    output logic [NUM_LANES-1:0]      nonce_we,
    output logic [32*NUM_LANES-1:0]   nonce_din,
    input  logic [NUM_LANES-1:0]      nonce_full,
    output logic                      stop_ack,
    output logic                      done,
    output logic [31:0]               nonce_end,
    output logic [31:0]               issued_cnt
);
    localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned NP = 1 << LW;
    localparam logic [LW:0]   NL   = (LW+1)'(NUM_LANES);
    localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RANGE, S_ISSUE, S_BURST} state_t;

    state_t        state_q, state_d;
    logic [639:0]  hdr_q, hdr_d;
    logic [639:0]  pkt_q, pkt_d;
    logic [4:0]    wcnt_q, wcnt_d;
    logic [31:0]   size_q, size_d;
    logic [32:0]   cur_q, cur_d;
    logic [32:0]   end_q, end_d;
    logic [31:0]   nonce_end_q, nonce_end_d;
    logic [31:0]   issued_q, issued_d;
    logic [LW-1:0] rr_q, rr_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [3:0]    beat_q, beat_d;
    logic          done_q, done_d;

    logic [40:0]   base_w, end_w;
    logic [NP-1:0] elig_pad;
    logic [LW:0]   idx;
    logic          grant_ok;
    logic [LW-1:0] grant_lane;
    logic          beat_wr;

    // 41 bits hold nonce_size*255 plus w0 plus nonce_size without overflow
    assign base_w = {9'd0, hdr_q[31:0]} + ({9'd0, size_q} * 41'(SLICE_IDX));
    assign end_w  = base_w + {9'd0, size_q};

    always_comb begin
        elig_pad                 = '0;
        elig_pad[NUM_LANES-1:0]  = ~hashin_full & ~nonce_full;
        grant_ok                 = 1'b0;
        grant_lane               = '0;
        idx                      = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            idx = {1'b0, rr_q} + (LW+1)'(k);
            if (idx >= NL) idx = idx - NL;
            if (!grant_ok && elig_pad[idx[LW-1:0]]) begin
                grant_ok   = 1'b1;
                grant_lane = idx[LW-1:0];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        pkt_d       = pkt_q;
        wcnt_d      = wcnt_q;
        size_d      = size_q;
        cur_d       = cur_q;
        end_d       = end_q;
        nonce_end_d = nonce_end_q;
        issued_d    = issued_q;
        rr_d        = rr_q;
        lane_d      = lane_q;
        beat_d      = beat_q;
        done_d      = 1'b0;
        beat_wr     = 1'b0;
        hashin_we   = '0;
        hashin_din  = '0;
        nonce_we    = '0;
        nonce_din   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    size_d   = nonce_size;
                    issued_d = '0;
                    wcnt_d   = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (hdr_valid) begin
                    for (int unsigned k = 0; k < 20; k++)
                        if (wcnt_q == 5'(k)) hdr_d[32*k +: 32] = hdr_word;
                    wcnt_d = wcnt_q + 5'd1;
                    if (wcnt_q == 5'd19) state_d = S_RANGE;
                end
            end
            S_RANGE: begin
                if (size_q == '0 || base_w[40:32] != '0) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b1;
                    nonce_end_d = (base_w[40:32] != '0) ? '1 : base_w[31:0];
                end else begin
                    cur_d   = base_w[32:0];
                    state_d = S_ISSUE;
                    // 33-bit end keeps nonce 0xFFFFFFFF issuable
                    if (end_w[40:32] != '0) begin
                        end_d       = 33'h1_0000_0000;
                        nonce_end_d = '1;
                    end else begin
                        end_d       = {1'b0, end_w[31:0]};
                        nonce_end_d = end_w[31:0];
                    end
                end
            end
            S_ISSUE: begin
                if (stop || cur_q >= end_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (grant_ok) begin
                    for (int unsigned i = 0; i < NUM_LANES; i++) begin
                        if (LW'(i) == grant_lane) begin
                            hashin_we[i]          = 1'b1;
                            hashin_din[64*i +: 64] = PAD_WORD;
                            nonce_we[i]           = 1'b1;
                            nonce_din[32*i +: 32]  = cur_q[31:0];
                        end
                    end
                    pkt_d    = {hdr_q[639:32], cur_q[7:0], cur_q[15:8], cur_q[23:16], cur_q[31:24]};
                    cur_d    = cur_q + 33'd1;
                    issued_d = issued_q + 32'd1;
                    rr_d     = (grant_lane == LAST) ? '0 : grant_lane + 1'b1;
                    lane_d   = grant_lane;
                    beat_d   = '0;
                    state_d  = S_BURST;
                end
            end
            S_BURST: begin
                for (int unsigned i = 0; i < NUM_LANES; i++) begin
                    if (LW'(i) == lane_q && !hashin_full[i]) begin
                        hashin_we[i]          = 1'b1;
                        hashin_din[64*i +: 64] = pkt_q[639:576];
                        beat_wr               = 1'b1;
                    end
                end
                if (beat_wr) begin
                    pkt_d  = pkt_q << 64;
                    beat_d = beat_q + 4'd1;
                    if (beat_q == 4'd9) state_d = S_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hdr_q       <= '0;
            pkt_q       <= '0;
            wcnt_q      <= '0;
            size_q      <= '0;
            cur_q       <= '0;
            end_q       <= '0;
            nonce_end_q <= '0;
            issued_q    <= '0;
            rr_q        <= '0;
            lane_q      <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            pkt_q       <= pkt_d;
            wcnt_q      <= wcnt_d;
            size_q      <= size_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            nonce_end_q <= nonce_end_d;
            issued_q    <= issued_d;
            rr_q        <= rr_d;
            lane_q      <= lane_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
        end
    end

    assign hdr_ready  = (state_q == S_LOAD);
    assign stop_ack   = (state_q == S_IDLE);
    assign done       = done_q;
    assign nonce_end  = nonce_end_q;
    assign issued_cnt = issued_q;
endmodule

// File: tb/tb_nonce_gen_mc.sv
// Directed bench for nonce_gen_mc: range vectors from a table plus stall, stop,
// reset-during-load and out-of-range slice sequences.
module tb_nonce_gen_mc;
    localparam logic [63:0] PAD = 64'h8000000000000280;

    logic         clk = 1'b0;
    logic         rst, start, start2, stop, hdr_valid;
    logic [31:0]  hdr_word, nonce_size;
    logic [3:0]   hashin_full, nonce_full;
    logic         hdr_ready, stop_ack, done;
    logic [3:0]   hashin_we, nonce_we;
    logic [255:0] hashin_din;
    logic [127:0] nonce_din;
    logic [31:0]  nonce_end, issued_cnt;
    logic         hdr_ready2, stop_ack2, done2;
    logic [3:0]   hashin_we2, nonce_we2;
    logic [255:0] hashin_din2;
    logic [127:0] nonce_din2;
    logic [31:0]  nonce_end2, issued_cnt2;

    always #5 clk = ~clk;

    nonce_gen_mc #(.NUM_LANES(4), .SLICE_IDX(0), .PAD_WORD(PAD)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready), .hdr_word(hdr_word), .nonce_size(nonce_size),
        .hashin_we(hashin_we), .hashin_din(hashin_din), .hashin_full(hashin_full),
        .nonce_we(nonce_we), .nonce_din(nonce_din), .nonce_full(nonce_full),
        .stop_ack(stop_ack), .done(done), .nonce_end(nonce_end), .issued_cnt(issued_cnt));

    nonce_gen_mc #(.NUM_LANES(4), .SLICE_IDX(2), .PAD_WORD(PAD)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop), .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready2), .hdr_word(hdr_word), .nonce_size(nonce_size),
        .hashin_we(hashin_we2), .hashin_din(hashin_din2), .hashin_full(hashin_full),
        .nonce_we(nonce_we2), .nonce_din(nonce_din2), .nonce_full(nonce_full),
        .stop_ack(stop_ack2), .done(done2), .nonce_end(nonce_end2), .issued_cnt(issued_cnt2));

    typedef struct { int lane; logic [63:0] data; } wr_t;
    typedef struct { logic [31:0] w0; logic [31:0] size; logic [31:0] exp_end; int exp_cnt; } vec_t;

    wr_t          hq[$];
    wr_t          nq[$];
    int           checks = 0, errors = 0;
    int           multi_cnt = 0, full_wr_cnt = 0, dirty_cnt = 0, dut2_wr = 0;
    int           exp_rr = 0;
    logic [639:0] cur_hdr;
    vec_t         vecs[5];

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (hashin_we[i]) begin
                    hq.push_back('{i, hashin_din[64*i +: 64]});
                    if (hashin_full[i]) full_wr_cnt++;
                end else if (hashin_din[64*i +: 64] != 64'd0) dirty_cnt++;
                if (nonce_we[i]) begin
                    nq.push_back('{i, {32'd0, nonce_din[32*i +: 32]}});
                    if (nonce_full[i]) full_wr_cnt++;
                end else if (nonce_din[32*i +: 32] != 32'd0) dirty_cnt++;
            end
            if ($countones(hashin_we | nonce_we) > 1) multi_cnt++;
            if (hashin_we2 != 4'd0 || nonce_we2 != 4'd0) dut2_wr++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat(input logic [31:0] n, input int j);
        logic [639:0] p;
        if (j == 0) return PAD;
        p = {cur_hdr[639:32], n[7:0], n[15:8], n[23:16], n[31:24]};
        return p[639-64*(j-1) -: 64];
    endfunction

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_rr = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, " hdr_ready"}, hdr_ready, 0);
        chk({tag, " stop_ack"}, stop_ack, 1);
        chk({tag, " done"}, done, 0);
        chk({tag, " nonce_end"}, nonce_end, 0);
        chk({tag, " issued_cnt"}, issued_cnt, 0);
        chk({tag, " we"}, {hashin_we, nonce_we}, 0);
    endtask

    task automatic send_header(input bit sel, input logic [31:0] w0, input logic [31:0] size, input int nwords);
        bit rdy;
        int n;
        for (int k = 0; k < 20; k++) cur_hdr[32*k +: 32] = 32'h0BAD0000 + 32'h01010101 * k;
        cur_hdr[31:0] = w0;
        nonce_size = size;
        @(posedge clk); #1;
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            hdr_valid = 1'b1;
            hdr_word  = cur_hdr[32*k +: 32];
            n = 0;
            do begin
                @(negedge clk);
                rdy = sel ? hdr_ready2 : hdr_ready;
                @(posedge clk); #1;
                n++;
            end while (!rdy && n < 50);
            if (!rdy) chk($sformatf("hdr_accept word%0d", k), rdy, 1);
        end
        hdr_valid = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        bit got = 0;
        for (int n = 0; n < 3000 && !got; n++) begin
            @(negedge clk);
            if ((sel ? done2 : done) === 1'b1) got = 1;
        end
        chk({tag, " done"}, got, 1);
        if (got) begin
            chk({tag, " stop_ack_at_done"}, sel ? stop_ack2 : stop_ack, 1);
            @(negedge clk);
            chk({tag, " done_pulse"}, sel ? done2 : done, 0);
        end
    endtask

    task automatic wait_nonces(input int cnt, input string tag);
        int n = 0;
        while (nq.size() < cnt && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (nq.size() < cnt) chk({tag, " nonce_wait"}, nq.size(), cnt);
    endtask

    task automatic check_nonces(input string tag, input logic [31:0] first, input int cnt);
        chk({tag, " nonce_count"}, nq.size(), cnt);
        for (int i = 0; i < nq.size() && i < cnt; i++) begin
            chk($sformatf("%s nonce%0d", tag, i), nq[i].data[31:0], first + i);
            chk($sformatf("%s lane%0d", tag, i), nq[i].lane, exp_rr);
            exp_rr = (exp_rr + 1) % 4;
        end
    endtask

    task automatic check_streams(input string tag);
        logic [63:0] act[$];
        logic [63:0] exq[$];
        int bad;
        for (int l = 0; l < 4; l++) begin
            act.delete(); exq.delete();
            foreach (hq[i]) if (hq[i].lane == l) act.push_back(hq[i].data);
            foreach (nq[i])
                if (nq[i].lane == l)
                    for (int j = 0; j <= 10; j++) exq.push_back(exp_beat(nq[i].data[31:0], j));
            if (act.size() != exq.size()) begin
                chk($sformatf("%s lane%0d beat_count", tag, l), act.size(), exq.size());
            end else begin
                bad = -1;
                foreach (act[i]) if (bad < 0 && act[i] !== exq[i]) bad = i;
                if (bad < 0) chk($sformatf("%s lane%0d stream", tag, l), act.size(), exq.size());
                else chk($sformatf("%s lane%0d beat%0d", tag, l, bad), act[bad], exq[bad]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int skip_lanes[6];
        skip_lanes = '{0, 2, 3, 0, 2, 3};
        vecs[0] = '{32'h0000_0010, 32'd8, 32'h0000_0018, 8};
        vecs[1] = '{32'hFFFF_FFFE, 32'd4, 32'hFFFF_FFFF, 2};
        vecs[2] = '{32'h0000_0100, 32'd0, 32'h0000_0100, 0};
        vecs[3] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1};
        vecs[4] = '{32'h7FFF_FFFC, 32'd3, 32'h7FFF_FFFF, 3};

        rst = 1'b1; start = 0; start2 = 0; stop = 0; hdr_valid = 0;
        hdr_word = '0; nonce_size = '0; hashin_full = '0; nonce_full = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_vals("reset");

        for (int v = 0; v < 5; v++) begin
            hq.delete(); nq.delete();
            send_header(0, vecs[v].w0, vecs[v].size, 20);
            wait_done(0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d nonce_end", v), nonce_end, vecs[v].exp_end);
            chk($sformatf("vec%0d issued_cnt", v), issued_cnt, vecs[v].exp_cnt);
            check_nonces($sformatf("vec%0d", v), vecs[v].w0, vecs[v].exp_cnt);
            check_streams($sformatf("vec%0d", v));
            if (v == 0 && hq.size() > 10) begin
                chk("vec0 first_pad", hq[0].data, PAD);
                chk("vec0 last_beat_low", hq[10].data[31:0], 32'h1000_0000);
            end
        end

        // lane 1 blocked throughout, lane 2 stalled mid-burst
        do_reset();
        hq.delete(); nq.delete();
        hashin_full = 4'b0010;
        send_header(0, 32'h0000_0200, 32'd6, 20);
        fork
            wait_done(0, "skip");
            begin
                wait_nonces(2, "stall");
                repeat (3) @(posedge clk);
                #1 hashin_full[2] = 1'b1;
                repeat (5) @(posedge clk);
                #1 hashin_full[2] = 1'b0;
            end
        join
        hashin_full = 4'b0000;
        chk("skip nonce_count", nq.size(), 6);
        for (int i = 0; i < 6 && i < nq.size(); i++) begin
            chk($sformatf("skip lane%0d", i), nq[i].lane, skip_lanes[i]);
            chk($sformatf("skip nonce%0d", i), nq[i].data[31:0], 32'h200 + i);
        end
        check_streams("skip");
        chk("skip issued_cnt", issued_cnt, 6);

        // stop during beat 4 of the first packet
        exp_rr = 0;
        hq.delete(); nq.delete();
        send_header(0, 32'h0000_0300, 32'd100, 20);
        wait_nonces(1, "stop");
        repeat (4) @(posedge clk);
        #1 stop = 1'b1;
        wait_done(0, "stop");
        stop = 1'b0;
        repeat (30) @(negedge clk);
        check_nonces("stop", 32'h300, 1);
        check_streams("stop");
        chk("stop issued_cnt", issued_cnt, 1);
        chk("stop nonce_end", nonce_end, 32'h364);
        chk("stop stop_ack", stop_ack, 1);

        // reset after a partial header, then a clean full load
        hq.delete(); nq.delete();
        send_header(0, 32'hDEAD_0000, 32'd5, 7);
        do_reset();
        check_reset_vals("rst_load");
        send_header(0, 32'h0000_4000, 32'd1, 20);
        wait_done(0, "rst_load");
        check_nonces("rst_load", 32'h4000, 1);
        check_streams("rst_load");
        chk("rst_load nonce_end", nonce_end, 32'h4001);

        // SLICE_IDX=2 pushes the base past 2^32
        send_header(1, 32'hFFFF_FF00, 32'h0000_0100, 20);
        wait_done(1, "slice2");
        chk("slice2 nonce_end", nonce_end2, 32'hFFFF_FFFF);
        chk("slice2 issued_cnt", issued_cnt2, 0);
        chk("slice2 writes", dut2_wr, 0);

        chk("one_lane_per_cycle", multi_cnt, 0);
        chk("write_while_full", full_wr_cnt, 0);
        chk("idle_lane_din_zero", dirty_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
